// File: rtl/sram_pkg.sv
// Shared constants for the asynchronous SRAM controller: FSM encodings, wait-counter width
// and the inactive strobe pattern.
package sram_pkg;

  localparam int CNT_W = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RD_ACC = 3'd1;
  localparam logic [2:0] ST_WR_ACC = 3'd2;
  localparam logic [2:0] ST_WR_REL = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Strobe vector ordering: {ce_n, oe_n, we_n, ub_n, lb_n}
  localparam logic [4:0] STROBE_IDLE = 5'b11111;

endpackage

// File: rtl/sram_ctrl.sv
// Multi-cycle controller for the external 256Kx16 asynchronous SRAM with programmable wait states.
// Pins are registered from the next-state decode, so they change together with the state.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [17:0] i_RAM_addr,
  input  logic [15:0] i_RAM_write,
  input  logic [1:0]  i_RAM_be,
  input  logic        i_RAM_we,
  input  logic        i_RAM_re,
  output logic [15:0] o_RAM_read,
  output logic        o_RAM_ack,
  output logic        o_RAM_busy,
  output logic [17:0] o_SRAM_addr,
  inout  wire  [15:0] io_SRAM_dq,
  output logic        o_SRAM_ce_n,
  output logic        o_SRAM_oe_n,
  output logic        o_SRAM_we_n,
  output logic        o_SRAM_ub_n,
  output logic        o_SRAM_lb_n
);

  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_CYCLES);

  logic [2:0]       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [17:0]      addr_s;
  logic [15:0]      wdata_r, wdata_s;
  logic [1:0]       be_r, be_s;
  logic             latch_s;
  logic [4:0]       strobe_r, strobe_s;
  logic             dq_oe_r, dq_oe_s;

  // Next state, wait counter and request capture; write wins when both requests are high
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    addr_s  = o_SRAM_addr;
    wdata_s = wdata_r;
    be_s    = be_r;
    latch_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_RAM_we) begin
          state_s = ST_WR_ACC;
          cnt_s   = {CNT_W{1'b0}};
          addr_s  = i_RAM_addr;
          wdata_s = i_RAM_write;
          be_s    = i_RAM_be;
        end else if (i_RAM_re) begin
          state_s = ST_RD_ACC;
          cnt_s   = {CNT_W{1'b0}};
          addr_s  = i_RAM_addr;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD_ACC: begin
        if (cnt_r == WAIT_LIM) begin
          state_s = ST_DONE;
          latch_s = 1'b1;
        end else begin
          cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_WR_ACC: begin
        if (cnt_r == WAIT_LIM) begin
          state_s = ST_WR_REL;
        end else begin
          cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_WR_REL: state_s = ST_DONE;
      ST_DONE:   state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Pin decode for the upcoming state; dq is only driven while oe_n is high
  always_comb begin
    strobe_s = STROBE_IDLE;
    dq_oe_s  = 1'b0;
    case (state_s)
      ST_RD_ACC: begin
        strobe_s = 5'b00100;
        dq_oe_s  = 1'b0;
      end
      ST_WR_ACC: begin
        strobe_s = {3'b010, ~be_s};
        dq_oe_s  = 1'b1;
      end
      ST_WR_REL: begin
        strobe_s = {3'b011, ~be_s};
        dq_oe_s  = 1'b1;
      end
      default: begin
        strobe_s = STROBE_IDLE;
        dq_oe_s  = 1'b0;
      end
    endcase
  end

  // State, captured request and registered pin/bus outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      o_SRAM_addr <= 18'd0;
      wdata_r     <= 16'd0;
      be_r        <= 2'b00;
      strobe_r    <= STROBE_IDLE;
      dq_oe_r     <= 1'b0;
      o_RAM_read  <= 16'd0;
      o_RAM_ack   <= 1'b0;
      o_RAM_busy  <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      o_SRAM_addr <= addr_s;
      wdata_r     <= wdata_s;
      be_r        <= be_s;
      strobe_r    <= strobe_s;
      dq_oe_r     <= dq_oe_s;
      o_RAM_ack   <= (state_s == ST_DONE);
      o_RAM_busy  <= (state_s != ST_IDLE);
      if (latch_s) begin
        o_RAM_read <= io_SRAM_dq;
      end else begin
        o_RAM_read <= o_RAM_read;
      end
    end
  end

  assign o_SRAM_ce_n = strobe_r[4];
  assign o_SRAM_oe_n = strobe_r[3];
  assign o_SRAM_we_n = strobe_r[2];
  assign o_SRAM_ub_n = strobe_r[1];
  assign o_SRAM_lb_n = strobe_r[0];

  assign io_SRAM_dq = dq_oe_r ? wdata_r : 16'hzzzz;

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: three instances (WAIT_CYCLES 0, 1, 15) share one request bus,
// each with its own behavioural asynchronous SRAM model.
module tb_sram_ctrl;

  localparam int WV [3] = '{0, 1, 15};

  typedef struct {
    int          ack_at;
    logic [15:0] rdata;
    logic [1:0]  lanes;
    int          we_cyc;
    int          oe_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [17:0] ram_addr = 18'd0;
  logic [15:0] ram_write = 16'd0;
  logic [1:0]  ram_be = 2'b00;
  logic        ram_we = 1'b0;
  logic        ram_re = 1'b0;

  logic [15:0] rd [3];
  logic [17:0] saddr [3];
  logic        ack [3], busy [3], ce_n [3], oe_n [3], we_n [3], ub_n [3], lb_n [3];
  wire  [15:0] dq0, dq1, dq2;
  logic [15:0] dqv [3];

  logic [15:0] mem [3][262144];
  logic        pre_req = 1'b0;
  logic [17:0] pre_addr = 18'd0;
  logic [15:0] pre_data = 16'd0;

  exp_t        sb [3][$];
  logic [15:0] exp_last [3] = '{default: 16'h0000};
  int          cyc = 0;
  int          we_cnt [3] = '{default: 0};
  int          oe_cnt [3] = '{default: 0};
  logic [1:0]  lanes_seen [3] = '{default: 2'b11};
  int          idle_run [3] = '{default: 0};
  logic        busy_q [3] = '{default: 1'b0};
  logic        b2b_armed [3] = '{default: 1'b0};
  logic        b2b_mode = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  sram_ctrl #(.WAIT_CYCLES(0)) u_w0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_RAM_addr(ram_addr), .i_RAM_write(ram_write),
    .i_RAM_be(ram_be), .i_RAM_we(ram_we), .i_RAM_re(ram_re), .o_RAM_read(rd[0]),
    .o_RAM_ack(ack[0]), .o_RAM_busy(busy[0]), .o_SRAM_addr(saddr[0]), .io_SRAM_dq(dq0),
    .o_SRAM_ce_n(ce_n[0]), .o_SRAM_oe_n(oe_n[0]), .o_SRAM_we_n(we_n[0]),
    .o_SRAM_ub_n(ub_n[0]), .o_SRAM_lb_n(lb_n[0]));

  sram_ctrl #(.WAIT_CYCLES(1)) u_w1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_RAM_addr(ram_addr), .i_RAM_write(ram_write),
    .i_RAM_be(ram_be), .i_RAM_we(ram_we), .i_RAM_re(ram_re), .o_RAM_read(rd[1]),
    .o_RAM_ack(ack[1]), .o_RAM_busy(busy[1]), .o_SRAM_addr(saddr[1]), .io_SRAM_dq(dq1),
    .o_SRAM_ce_n(ce_n[1]), .o_SRAM_oe_n(oe_n[1]), .o_SRAM_we_n(we_n[1]),
    .o_SRAM_ub_n(ub_n[1]), .o_SRAM_lb_n(lb_n[1]));

  sram_ctrl #(.WAIT_CYCLES(15)) u_w15 (
    .i_clk(clk), .i_rst_n(rst_n), .i_RAM_addr(ram_addr), .i_RAM_write(ram_write),
    .i_RAM_be(ram_be), .i_RAM_we(ram_we), .i_RAM_re(ram_re), .o_RAM_read(rd[2]),
    .o_RAM_ack(ack[2]), .o_RAM_busy(busy[2]), .o_SRAM_addr(saddr[2]), .io_SRAM_dq(dq2),
    .o_SRAM_ce_n(ce_n[2]), .o_SRAM_oe_n(oe_n[2]), .o_SRAM_we_n(we_n[2]),
    .o_SRAM_ub_n(ub_n[2]), .o_SRAM_lb_n(lb_n[2]));

  // SRAM models drive dq only for a read strobe pattern
  assign dq0 = (!ce_n[0] && !oe_n[0] && we_n[0]) ? mem[0][saddr[0]] : 16'hzzzz;
  assign dq1 = (!ce_n[1] && !oe_n[1] && we_n[1]) ? mem[1][saddr[1]] : 16'hzzzz;
  assign dq2 = (!ce_n[2] && !oe_n[2] && we_n[2]) ? mem[2][saddr[2]] : 16'hzzzz;
  assign dqv[0] = dq0;
  assign dqv[1] = dq1;
  assign dqv[2] = dq2;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model write port and bench-side preload, sampled mid-cycle
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (pre_req) begin
        mem[i][pre_addr] <= pre_data;
      end else if (!ce_n[i] && !we_n[i]) begin
        if (!lb_n[i]) mem[i][saddr[i]][7:0] <= dqv[i][7:0];
        if (!ub_n[i]) mem[i][saddr[i]][15:8] <= dqv[i][15:8];
      end
    end
  end

  // Monitor: strobe accounting and scoreboard pop on every ack
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin : mon
      exp_t e;
      if (ack[i]) begin
        check_eq($sformatf("w%0d_ack_expected", WV[i]), 32'(sb[i].size() > 0), 32'd1);
        if (sb[i].size() > 0) begin
          e = sb[i].pop_front();
          check_eq($sformatf("w%0d_ack_cycle", WV[i]), 32'(cyc), 32'(e.ack_at));
          check_eq($sformatf("w%0d_rdata", WV[i]), 32'(rd[i]), 32'(e.rdata));
          check_eq($sformatf("w%0d_lanes", WV[i]), 32'(lanes_seen[i]), 32'(e.lanes));
          check_eq($sformatf("w%0d_we_cycles", WV[i]), 32'(we_cnt[i]), 32'(e.we_cyc));
          check_eq($sformatf("w%0d_oe_cycles", WV[i]), 32'(oe_cnt[i]), 32'(e.oe_cyc));
          check_eq($sformatf("w%0d_busy_at_ack", WV[i]), 32'(busy[i]), 32'd1);
        end
      end
      if (busy[i] && !busy_q[i] && b2b_mode && b2b_armed[i])
        check_eq($sformatf("w%0d_b2b_idle_gap", WV[i]), 32'(idle_run[i]), 32'd1);
      we_cnt[i]     <= ack[i] ? 0 : (!we_n[i] ? we_cnt[i] + 1 : we_cnt[i]);
      oe_cnt[i]     <= ack[i] ? 0 : (!oe_n[i] ? oe_cnt[i] + 1 : oe_cnt[i]);
      lanes_seen[i] <= ack[i] ? 2'b11 :
                       ((!we_n[i] || !oe_n[i]) ? {ub_n[i], lb_n[i]} : lanes_seen[i]);
      idle_run[i]   <= busy[i] ? 0 : idle_run[i] + 1;
      busy_q[i]     <= busy[i];
      b2b_armed[i]  <= b2b_mode && (b2b_armed[i] || ack[i]);
    end
  end

  task automatic preload(input logic [17:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    pre_addr = a;
    pre_data = d;
    pre_req  = 1'b1;
    @(posedge clk); #1;
    pre_req  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_timeout", 32'(sb[0].size() + sb[1].size() + sb[2].size()), 32'd0);
    for (int i = 0; i < 3; i++) sb[i].delete();
    @(negedge clk);
  endtask

  // One request presented for a single cycle; expectations pushed as it is driven
  task automatic access(input bit wr, input bit rq, input logic [17:0] a, input logic [15:0] d,
                        input logic [1:0] be, input logic [15:0] exp_rd);
    @(negedge clk);
    ram_addr  = a;
    ram_write = d;
    ram_be    = be;
    ram_we    = wr;
    ram_re    = rq;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.ack_at = cyc + WV[i] + (wr ? 3 : 2);
      e.rdata  = wr ? exp_last[i] : exp_rd;
      e.lanes  = wr ? ~be : 2'b00;
      e.we_cyc = wr ? WV[i] + 1 : 0;
      e.oe_cyc = wr ? 0 : WV[i] + 1;
      sb[i].push_back(e);
      if (!wr) exp_last[i] = exp_rd;
    end
    @(negedge clk);
    ram_we = 1'b0;
    ram_re = 1'b0;
    drain();
  endtask

  task automatic check_idle_pins(input string tag);
    for (int i = 0; i < 3; i++)
      check_eq($sformatf("w%0d_%s", WV[i], tag),
               {25'd0, ce_n[i], oe_n[i], we_n[i], ub_n[i], lb_n[i], ack[i], busy[i]},
               {25'd0, 7'b1111100});
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check_idle_pins("reset_pins");
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("w%0d_reset_rdata", WV[i]), 32'(rd[i]), 32'd0);
      check_eq($sformatf("w%0d_reset_addr", WV[i]), 32'(saddr[i]), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    preload(18'h22B3C, 16'hBEEF);
    preload(18'h00010, 16'h7700);
    preload(18'h00200, 16'h1111);
    preload(18'h00300, 16'hC0DE);

    access(1'b0, 1'b1, 18'h22B3C, 16'h0000, 2'b00, 16'hBEEF);
    access(1'b1, 1'b0, 18'h00010, 16'h00AB, 2'b01, 16'h0000);
    for (int i = 0; i < 3; i++)
      check_eq($sformatf("w%0d_byte_write_mem", WV[i]), 32'(mem[i][18'h00010]), 32'h77AB);
    access(1'b1, 1'b1, 18'h3FFFF, 16'h1234, 2'b11, 16'h0000);
    for (int i = 0; i < 3; i++)
      check_eq($sformatf("w%0d_wr_wins_mem", WV[i]), 32'(mem[i][18'h3FFFF]), 32'h1234);
    access(1'b1, 1'b0, 18'h01234, 16'h5A5A, 2'b11, 16'h0000);
    access(1'b0, 1'b1, 18'h01234, 16'h0000, 2'b00, 16'h5A5A);

    // Abort a write just after its first access edge
    @(negedge clk);
    ram_addr  = 18'h00200;
    ram_write = 16'hFFFF;
    ram_be    = 2'b11;
    ram_we    = 1'b1;
    @(posedge clk); #1;
    rst_n  = 1'b0;
    ram_we = 1'b0;
    #1;
    check_idle_pins("midreset_pins");
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        check_eq($sformatf("w%0d_midreset_no_ack", WV[i]), 32'(ack[i]), 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("w%0d_aborted_mem", WV[i]), 32'(mem[i][18'h00200]), 32'h1111);
      exp_last[i] = 16'h0000;
    end
    rst_n = 1'b1;
    access(1'b0, 1'b1, 18'h00200, 16'h0000, 2'b00, 16'h1111);

    // Continuous read request: one access every W+3 cycles
    b2b_mode = 1'b1;
    @(negedge clk);
    ram_addr = 18'h00300;
    ram_re   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k * (WV[i] + 3) <= 39; k++) begin
        exp_t e;
        e.ack_at = cyc + k * (WV[i] + 3) + WV[i] + 2;
        e.rdata  = 16'hC0DE;
        e.lanes  = 2'b00;
        e.we_cyc = 0;
        e.oe_cyc = WV[i] + 1;
        sb[i].push_back(e);
      end
      exp_last[i] = 16'hC0DE;
    end
    repeat (40) @(negedge clk);
    ram_re = 1'b0;
    drain();
    b2b_mode = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
